systolic_result_drain: RTL and testbench
========================================

# systolic_result_drain

Result-side companion to the systolic array top level. Captures the N×N matrix of 32-bit products when the array pulses its result-valid strobe, then streams the elements out one per beat, row-major, over a valid/ready interface with a last marker. Asserts a busy flag while draining so the issuing logic can hold off the next multiply. Flags a sticky overrun if a new result arrives before the drain completes.

## Interface
- N, 4, matrix dimension; legal range 2..15
- W, 32, element width in bits; matches the array result width
- i_clk  in  1  clock; all state updates on rising edge
- i_arst_n  in  1  asynchronous, active-low reset
- i_c  in  [N-1:0][N-1:0][W-1:0]  result matrix, indexed [row][col]; sampled only on i_validResult
- i_validResult  in  1  single-cycle capture strobe from the array
- o_busy  out  1  high while the drain buffer holds undelivered elements
- o_valid  out  1  output element valid
- i_ready  in  1  downstream accept
- o_data  out  W  current element, buf[row][col]
- o_row  out  $clog2(N)  row index of o_data
- o_col  out  $clog2(N)  column index of o_data
- o_last  out  1  high with o_valid on element [N-1][N-1]
- o_overrun  out  1  sticky: a result was dropped
- i_clearOverrun  in  1  synchronous clear of o_overrun

## Operation
- States: IDLE, DRAIN.
- IDLE: o_valid=0, o_busy=0. On i_validResult: copy i_c into buffer, idx=0, go to DRAIN.
- DRAIN: o_valid=1, o_busy=1. o_data/o_row/o_col come from idx (row=idx/N, col=idx%N; shift/mask when N is a power of two).
- Handshake: beat completes when o_valid&&i_ready. On completion idx increments. On completion at idx=N*N-1, return to IDLE.
- While o_valid && !i_ready: o_data, o_row, o_col, o_last held stable. o_valid never drops without a completed beat.
- Overrun: i_validResult in DRAIN, other than on the final completing beat, sets o_overrun. The new matrix is discarded; buffer and idx are unchanged.
- Final beat coincident with i_validResult: capture the new matrix, idx=0, stay in DRAIN. No overrun and no idle gap.
- i_clearOverrun and an overrun event in the same cycle: o_overrun stays set (set wins).
- idx register width $clog2(N*N). No wrap beyond N*N-1.

## Timing
- Reset values: o_valid=0, o_busy=0, o_last=0, o_overrun=0, o_data=0, o_row=0, o_col=0, state IDLE, buffer zeroed.
- Capture edge t: o_valid and o_busy are high from cycle t+1.
- With i_ready held high: exactly N*N consecutive beats; o_busy falls the cycle after the last beat.
- All outputs come directly from registers or from a mux of registers indexed by a registered idx. No combinational path from i_ready or i_validResult to any output.
- Reset asserted mid-drain: outputs go to reset values asynchronously. The drain is abandoned and does not resume after release.

## Structure
- Shared package systolic_pkg: state enum (IDLE, DRAIN), default element width constant (32), default N.
- No sub-module. Capture buffer, index counter, FSM and overrun flag are all inline; the read mux is a generate over rows.

## Test plan
- Reset, with i_arst_n low for 3 cycles → all outputs 0; o_busy=0 after release.
- Basic drain: i_c[r][c]=r*16+c, N=4, i_ready=1, single strobe → 16 beats, o_data 0,1,2,3,16,…,51; (o_row,o_col) match each beat; o_last only on data 51; o_busy low at cycle 18.
- Back-pressure: same matrix, i_ready pattern 1,0,1,0… → 32 cycles of o_valid; o_data unchanged across every ready=0 cycle; order identical to the basic drain.
- Overrun: second strobe with all-0xFF matrix at beat 5 → o_overrun=1; remaining beats still 17…51; i_clearOverrun pulse → o_overrun=0.
- Back-to-back: second strobe on the cycle of the 16th handshake → next cycle o_data=second matrix [0][0], o_valid never drops, o_overrun stays 0.
- Mid-drain reset: assert i_arst_n=0 at beat 7 → o_valid=0 in the same cycle; after release, o_valid stays 0 until a new strobe.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path: drain FSM states
// and the default matrix geometry.
package systolic_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drainState_e;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 32;

endpackage

// File: rtl/systolic_result_drain.sv
// Captures an NxN result matrix on the array's valid strobe and streams it out
// row-major over valid/ready, flagging a sticky overrun for results that arrive mid-drain.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic                            i_clk,
  input  logic                            i_arst_n,
  input  logic [N-1:0][N-1:0][W-1:0]      i_c,
  input  logic                            i_validResult,
  output logic                            o_busy,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [W-1:0]                    o_data,
  output logic [$clog2(N)-1:0]            o_row,
  output logic [$clog2(N)-1:0]            o_col,
  output logic                            o_last,
  output logic                            o_overrun,
  input  logic                            i_clearOverrun
);

  localparam int RW = $clog2(N);
  localparam int IW = $clog2(N * N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);

  drainState_e                 state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [N-1:0][N-1:0][W-1:0]  capBuf_q;
  logic                        overrun_q, overrun_d;
  logic                        capture;
  logic                        setOverrun;
  logic                        beatDone;
  logic                        finalBeat;
  logic [RW-1:0]               rowIdx;
  logic [RW-1:0]               colIdx;
  logic [N-1:0][W-1:0]         rowData;

  assign beatDone  = (state_q == DRAIN) && i_ready;
  assign finalBeat = beatDone && (idx_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    capture    = 1'b0;
    setOverrun = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_validResult) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (finalBeat) begin
          idx_d = '0;
          // A strobe on the final beat reloads without an idle gap.
          if (i_validResult) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (beatDone) begin
            idx_d = idx_q + IW'(1);
          end
          if (i_validResult) begin
            setOverrun = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign overrun_d = (overrun_q && !i_clearOverrun) || setOverrun;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      capBuf_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      if (capture) begin
        capBuf_q <= i_c;
      end
    end
  end

  // Row/column decode of the registered index; reduces to shift/mask for power-of-two N.
  assign rowIdx = RW'(idx_q / IW'(N));
  assign colIdx = RW'(idx_q % IW'(N));

  for (genvar r = 0; r < N; r++) begin : g_rowMux
    assign rowData[r] = capBuf_q[r][colIdx];
  end

  assign o_data    = rowData[rowIdx];
  assign o_row     = rowIdx;
  assign o_col     = colIdx;
  assign o_valid   = (state_q == DRAIN);
  assign o_busy    = (state_q == DRAIN);
  assign o_last    = (state_q == DRAIN) && (idx_q == LAST_IDX);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: reset, scripted vector table,
// hand-written corner sequences and randomized traffic against a matrix-level model.
module tb_systolic_result_drain;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int RW = $clog2(N);

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  typedef struct {
    bit             vr;
    bit             rdy;
    bit             clr;
    bit             useB;
    bit             valid;
    bit             ov;
    logic [W-1:0]   data;
    int             row;
    int             col;
  } vec_t;

  logic           clk = 1'b0;
  logic           rstN;
  mat_t           cIn;
  logic           validResult;
  logic           busy;
  logic           oValid;
  logic           ready;
  logic [W-1:0]   oData;
  logic [RW-1:0]  oRow;
  logic [RW-1:0]  oCol;
  logic           oLast;
  logic           overrun;
  logic           clearOverrun;

  int   errors = 0;
  int   checks = 0;

  mat_t mMat;
  bit   mBusy;
  bit   mOv;
  int   mPos;

  mat_t matA;
  mat_t matB;
  mat_t matC;
  vec_t vecs[9];

  always #5 clk = ~clk;

  systolic_result_drain #(.N(N), .W(W)) dut (
    .i_clk          (clk),
    .i_arst_n       (rstN),
    .i_c            (cIn),
    .i_validResult  (validResult),
    .o_busy         (busy),
    .o_valid        (oValid),
    .i_ready        (ready),
    .o_data         (oData),
    .o_row          (oRow),
    .o_col          (oCol),
    .o_last         (oLast),
    .o_overrun      (overrun),
    .i_clearOverrun (clearOverrun)
  );

  task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMat  = '0;
    mBusy = 1'b0;
    mOv   = 1'b0;
    mPos  = 0;
  endtask

  // Matrix-level behaviour: a drain walks positions 0..N*N-1; a strobe loads only if the
  // buffer is free by the end of this cycle, otherwise it is dropped and recorded.
  task automatic modelStep(input bit vr, input bit rdy, input bit clr, input mat_t m);
    bit setNow;
    setNow = 1'b0;
    if (mBusy && rdy) begin
      mPos++;
      if (mPos == N * N) begin
        mBusy = 1'b0;
        mPos  = 0;
      end
    end
    if (vr) begin
      if (!mBusy) begin
        mMat  = m;
        mPos  = 0;
        mBusy = 1'b1;
      end else begin
        mOv    = 1'b1;
        setNow = 1'b1;
      end
    end
    if (clr && !setNow) mOv = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge with the model advanced.
  task automatic applyStimulus(input bit vr, input bit rdy, input bit clr, input mat_t m);
    validResult  = vr;
    ready        = rdy;
    clearOverrun = clr;
    cIn          = m;
    modelStep(vr, rdy, clr, m);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".valid"}, W'(oValid), W'(mBusy));
    checkVal({tag, ".busy"}, W'(busy), W'(mBusy));
    checkVal({tag, ".overrun"}, W'(overrun), W'(mOv));
    checkVal({tag, ".last"}, W'(oLast), W'(mBusy && (mPos == N * N - 1)));
    if (mBusy) begin
      checkVal({tag, ".data"}, oData, mMat[mPos / N][mPos % N]);
      checkVal({tag, ".row"}, W'(oRow), W'(mPos / N));
      checkVal({tag, ".col"}, W'(oCol), W'(mPos % N));
    end
  endtask

  task automatic drainOut(input string tag);
    for (int i = 0; i < 4 * N * N && mBusy; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput(tag);
    end
  endtask

  initial begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        matA[r][c] = W'(r * 16 + c);
        matB[r][c] = 32'hFF;
      end
    end

    // Scripted vectors: strobe with back-pressure, overrun, clear, set-beats-clear.
    vecs[0] = '{vr:1, rdy:0, clr:0, useB:0, valid:1, ov:0, data:0,  row:0, col:0};
    vecs[1] = '{vr:0, rdy:0, clr:0, useB:0, valid:1, ov:0, data:0,  row:0, col:0};
    vecs[2] = '{vr:0, rdy:1, clr:0, useB:0, valid:1, ov:0, data:1,  row:0, col:1};
    vecs[3] = '{vr:0, rdy:0, clr:0, useB:0, valid:1, ov:0, data:1,  row:0, col:1};
    vecs[4] = '{vr:0, rdy:1, clr:0, useB:0, valid:1, ov:0, data:2,  row:0, col:2};
    vecs[5] = '{vr:1, rdy:1, clr:0, useB:1, valid:1, ov:1, data:3,  row:0, col:3};
    vecs[6] = '{vr:0, rdy:0, clr:1, useB:0, valid:1, ov:0, data:3,  row:0, col:3};
    vecs[7] = '{vr:1, rdy:0, clr:1, useB:1, valid:1, ov:1, data:3,  row:0, col:3};
    vecs[8] = '{vr:0, rdy:1, clr:0, useB:0, valid:1, ov:1, data:16, row:1, col:0};

    rstN         = 1'b0;
    validResult  = 1'b0;
    ready        = 1'b0;
    clearOverrun = 1'b0;
    cIn          = '0;
    modelReset();

    repeat (3) @(negedge clk);
    checkVal("reset.valid", W'(oValid), '0);
    checkVal("reset.busy", W'(busy), '0);
    checkVal("reset.last", W'(oLast), '0);
    checkVal("reset.overrun", W'(overrun), '0);
    checkVal("reset.data", oData, '0);
    checkVal("reset.row", W'(oRow), '0);
    checkVal("reset.col", W'(oCol), '0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("postReset");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].vr, vecs[i].rdy, vecs[i].clr, vecs[i].useB ? matB : matA);
      checkVal($sformatf("vec%0d.valid", i), W'(oValid), W'(vecs[i].valid));
      checkVal($sformatf("vec%0d.overrun", i), W'(overrun), W'(vecs[i].ov));
      checkVal($sformatf("vec%0d.data", i), oData, vecs[i].data);
      checkVal($sformatf("vec%0d.row", i), W'(oRow), W'(vecs[i].row));
      checkVal($sformatf("vec%0d.col", i), W'(oCol), W'(vecs[i].col));
    end
    drainOut("tableDrain");
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("clearOv");

    // Basic drain with ready held high: N*N beats in row-major order, then idle.
    applyStimulus(1'b1, 1'b1, 1'b0, matA);
    for (int k = 0; k < N * N; k++) begin
      checkVal($sformatf("basic%0d.valid", k), W'(oValid), W'(1));
      checkVal($sformatf("basic%0d.data", k), oData, W'((k / N) * 16 + (k % N)));
      checkVal($sformatf("basic%0d.last", k), W'(oLast), W'(k == N * N - 1));
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
    end
    checkVal("basic.busyAfter", W'(busy), W'(0));
    checkVal("basic.validAfter", W'(oValid), W'(0));

    // Back-to-back: new strobe coincides with the final handshake.
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) matC[k][j] = $urandom;
    applyStimulus(1'b1, 1'b1, 1'b0, matA);
    for (int k = 0; k < N * N - 1; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkVal("b2b.lastBeat", W'(oLast), W'(1));
    applyStimulus(1'b1, 1'b1, 1'b0, matC);
    checkVal("b2b.valid", W'(oValid), W'(1));
    checkVal("b2b.data", oData, matC[0][0]);
    checkVal("b2b.overrun", W'(overrun), W'(0));
    drainOut("b2bDrain");

    // Reset in the middle of a drain abandons it immediately.
    applyStimulus(1'b1, 1'b1, 1'b0, matA);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkVal("midRst.before", oData, W'(16 + 3));
    #2 rstN = 1'b0;
    #1;
    checkVal("midRst.valid", W'(oValid), W'(0));
    checkVal("midRst.busy", W'(busy), W'(0));
    checkVal("midRst.data", oData, W'(0));
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("afterRst");
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      mat_t m;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) m[r][c] = $urandom;
      applyStimulus($urandom_range(0, 14) == 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 24) == 0, m);
      checkOutput("rand");
    end
    drainOut("finalDrain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
